// File: rtl/pcie_tlp_pkg.sv
// Shared types and constants for the 64-bit PCIe target completer.
// Contents: fmt/type codes, header field offsets, FSM state encodings,
// the completion descriptor handed to the TX sequencer, a debug struct,
// and the firstBE -> {byte_count, low2} helper.
package pcie_tlp_pkg;

  // {fmt[1:0], type[4:0]} as found in DW0[30:24]
  localparam logic [6:0] MRD32 = 7'b00_00000;
  localparam logic [6:0] MWR32 = 7'b10_00000;
  localparam logic [6:0] CPLD  = 7'b10_01010;

  // DW0 field offsets
  localparam int FMT_TYPE_LSB = 24;
  localparam int TC_LSB       = 20;
  localparam int ATTR_LSB     = 12;
  localparam int LEN_LSB      = 0;
  // DW1 field offsets
  localparam int REQID_LSB    = 16;
  localparam int TAG_LSB      = 8;
  localparam int FBE_LSB      = 0;

  typedef enum logic [2:0] {
    ST_IDLE, ST_HDR2, ST_RD_ISSUE, ST_RD_WAIT, ST_CPL, ST_DISCARD
  } state_e;

  typedef enum logic [1:0] {TX_IDLE, TX0, TX1} tx_state_e;

  typedef struct packed {
    logic [31:0] dw0;
    logic [31:0] dw1;
    logic [31:0] dw2;
    logic [31:0] rdata;
  } cpl_desc_t;

  typedef struct packed {
    state_e    top;
    tx_state_e tx;
  } dbg_t;

  // firstBE of 0000 is a zero-length read: report 1 byte at offset 0.
  function automatic logic [13:0] be_to_bytecount_lowaddr(input logic [3:0] be);
    logic [1:0] lo;
    logic [1:0] hi;
    logic [2:0] cnt;
    lo = 2'd0;
    hi = 2'd0;
    for (int i = 3; i >= 0; i--) if (be[i]) lo = i[1:0];
    for (int i = 0; i < 4; i++)  if (be[i]) hi = i[1:0];
    cnt = {1'b0, hi} - {1'b0, lo} + 3'd1;
    if (be == 4'b0000) begin
      cnt = 3'd1;
      lo  = 2'd0;
    end
    return {9'd0, cnt, lo};
  endfunction

endpackage

// File: rtl/pcie_tlp_completer_64_if.sv
// AXI-stream bundle used for both the RX request and TX completion streams.
// master drives tdata/tkeep/tlast/tvalid/tuser and samples tready;
// slave is the mirror image.
// Handshake: a beat transfers on a rising clock edge where tvalid && tready;
// once tvalid is raised the master holds tdata/tkeep/tlast stable until that
// transfer happens.
interface pcie_tlp_completer_64_if #(
  parameter int DATA_W = 64,
  parameter int USER_W = 22
);
  logic [DATA_W-1:0]   tdata;
  logic [DATA_W/8-1:0] tkeep;
  logic                tlast;
  logic                tvalid;
  logic                tready;
  logic [USER_W-1:0]   tuser;

  modport master (output tdata, tkeep, tlast, tvalid, tuser, input tready);
  modport slave  (input tdata, tkeep, tlast, tvalid, tuser, output tready);
endinterface

// File: rtl/pcie_cpld_tx_64.sv
// CplD beat sequencer: emits the two 64-bit beats of a 3DW completion with
// one data DW from a descriptor the parent holds stable while start is high.
// Ports: clk/rst_n, start (level, parent is waiting for a completion),
// desc (completion DWs + read data), tx_buf_av (core TX credits),
// tx (AXI-stream master), done (pulse on final beat accept), state (debug).
module pcie_cpld_tx_64
  import pcie_tlp_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  cpl_desc_t                      desc,
  input  logic [5:0]                     tx_buf_av,
  pcie_tlp_completer_64_if.master        tx,
  output logic                           done,
  output tx_state_e                      state
);

  tx_state_e state_q, state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= TX_IDLE;
    else        state_q <= state_d;
  end

  // Buffer availability is only checked before raising tvalid; once a beat is
  // offered it stays offered until tready, whatever tx_buf_av does.
  always_comb begin
    state_d   = state_q;
    done      = 1'b0;
    tx.tvalid = 1'b0;
    tx.tdata  = '0;
    tx.tkeep  = '0;
    tx.tlast  = 1'b0;
    case (state_q)
      TX_IDLE: if (start && (tx_buf_av != 6'd0)) state_d = TX0;
      TX0: begin
        tx.tvalid = 1'b1;
        tx.tdata  = {desc.dw1, desc.dw0};
        tx.tkeep  = '1;
        if (tx.tready) state_d = TX1;
      end
      TX1: begin
        tx.tvalid = 1'b1;
        tx.tdata  = {desc.rdata, desc.dw2};
        tx.tkeep  = '1;
        tx.tlast  = 1'b1;
        if (tx.tready) begin
          done    = 1'b1;
          state_d = TX_IDLE;
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  assign tx.tuser = '0;
  assign state    = state_q;

endmodule

// File: rtl/pcie_tlp_completer_64.sv
// Target-side TLP responder for the 7-series PCIe endpoint (64-bit AXIS).
// Accepts single-DW MRd/MWr 3DW TLPs hitting BAR0, drives a register
// read/write port and returns CplD TLPs. Everything else is sunk and flagged
// on ur_drop.
// Ports: user_clk/user_reset_n, m_axis_rx (RX slave), s_axis_tx (TX master),
// tx_buf_av, cfg_* (completer ID), rd_req_*/rd_rsp_* (register read),
// wr_* (register write strobe), ur_drop, dbg (FSM states).
module pcie_tlp_completer_64
  import pcie_tlp_pkg::*;
#(
  parameter int ADDR_WIDTH   = 10,
  parameter int C_DATA_WIDTH = 64
) (
  input  logic                    user_clk,
  input  logic                    user_reset_n,
  pcie_tlp_completer_64_if.slave  m_axis_rx,
  pcie_tlp_completer_64_if.master s_axis_tx,
  input  logic [5:0]              tx_buf_av,
  input  logic [7:0]              cfg_bus_number,
  input  logic [4:0]              cfg_device_number,
  input  logic [2:0]              cfg_function_number,
  output logic                    rd_req_valid,
  output logic [ADDR_WIDTH-1:0]   rd_req_addr,
  input  logic                    rd_req_ready,
  input  logic                    rd_rsp_valid,
  input  logic [31:0]             rd_rsp_data,
  output logic                    wr_valid,
  output logic [ADDR_WIDTH-1:0]   wr_addr,
  output logic [31:0]             wr_data,
  output logic [3:0]              wr_be,
  output logic                    ur_drop,
  output dbg_t                    dbg
);

  if (C_DATA_WIDTH != 64) begin : g_bad_width
    $error("pcie_tlp_completer_64: C_DATA_WIDTH must be 64");
  end

  state_e                state_q, state_d;
  logic                  is_wr_q, is_wr_d;
  logic [2:0]            tc_q, tc_d;
  logic [1:0]            attr_q, attr_d;
  logic [15:0]           reqid_q, reqid_d;
  logic [7:0]            tag_q, tag_d;
  logic [3:0]            be_q, be_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [4:0]            la_hi_q, la_hi_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  rdy_en_q;

  logic [31:0] dw_lo, dw_hi;
  logic        rx_fire, hdr_ok, cpl_done;
  logic [11:0] byte_count;
  logic [1:0]  low2;
  cpl_desc_t   desc;
  tx_state_e   tx_state;
  logic        unused_rx;

  // Beat0 carries DW0/DW1, beat1 carries DW2 (address) / DW3 (write data).
  assign dw_lo   = m_axis_rx.tdata[31:0];
  assign dw_hi   = m_axis_rx.tdata[63:32];
  assign rx_fire = m_axis_rx.tvalid && m_axis_rx.tready;

  // A good header must also not end on beat0, else HDR2 would eat the next TLP.
  assign hdr_ok = ((dw_lo[FMT_TYPE_LSB+:7] == MRD32) || (dw_lo[FMT_TYPE_LSB+:7] == MWR32))
                  && (dw_lo[LEN_LSB+:10] == 10'd1)
                  && m_axis_rx.tuser[2] && !m_axis_rx.tuser[1]
                  && !m_axis_rx.tlast;

  always_comb begin
    state_d  = state_q;
    is_wr_d  = is_wr_q;
    tc_d     = tc_q;
    attr_d   = attr_q;
    reqid_d  = reqid_q;
    tag_d    = tag_q;
    be_d     = be_q;
    addr_d   = addr_q;
    la_hi_d  = la_hi_q;
    rdata_d  = rdata_q;
    wr_valid = 1'b0;
    ur_drop  = 1'b0;
    case (state_q)
      ST_IDLE: if (rx_fire) begin
        if (hdr_ok) begin
          is_wr_d = dw_lo[30];
          tc_d    = dw_lo[TC_LSB+:3];
          attr_d  = dw_lo[ATTR_LSB+:2];
          reqid_d = dw_hi[REQID_LSB+:16];
          tag_d   = dw_hi[TAG_LSB+:8];
          be_d    = dw_hi[FBE_LSB+:4];
          state_d = ST_HDR2;
        end else begin
          ur_drop = 1'b1;
          state_d = m_axis_rx.tlast ? ST_IDLE : ST_DISCARD;
        end
      end
      ST_HDR2: if (rx_fire) begin
        addr_d  = dw_lo[ADDR_WIDTH+1:2];
        la_hi_d = dw_lo[6:2];
        if (!m_axis_rx.tlast)  state_d = ST_DISCARD;
        else if (is_wr_q) begin
          wr_valid = 1'b1;
          state_d  = ST_IDLE;
        end else               state_d = ST_RD_ISSUE;
      end
      ST_RD_ISSUE: if (rd_req_ready) begin
        if (rd_rsp_valid) begin
          rdata_d = rd_rsp_data;
          state_d = ST_CPL;
        end else state_d = ST_RD_WAIT;
      end
      ST_RD_WAIT: if (rd_rsp_valid) begin
        rdata_d = rd_rsp_data;
        state_d = ST_CPL;
      end
      ST_CPL:     if (cpl_done) state_d = ST_IDLE;
      ST_DISCARD: if (rx_fire && m_axis_rx.tlast) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge user_clk or negedge user_reset_n) begin
    if (!user_reset_n) begin
      state_q  <= ST_IDLE;
      is_wr_q  <= 1'b0;
      tc_q     <= '0;
      attr_q   <= '0;
      reqid_q  <= '0;
      tag_q    <= '0;
      be_q     <= '0;
      addr_q   <= '0;
      la_hi_q  <= '0;
      rdata_q  <= '0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      is_wr_q  <= is_wr_d;
      tc_q     <= tc_d;
      attr_q   <= attr_d;
      reqid_q  <= reqid_d;
      tag_q    <= tag_d;
      be_q     <= be_d;
      addr_q   <= addr_d;
      la_hi_q  <= la_hi_d;
      rdata_q  <= rdata_d;
      rdy_en_q <= 1'b1;
    end
  end

  // rdy_en_q keeps tready low while reset is held even though IDLE accepts.
  assign m_axis_rx.tready = rdy_en_q &&
         ((state_q == ST_IDLE) || (state_q == ST_HDR2) || (state_q == ST_DISCARD));

  assign rd_req_valid = (state_q == ST_RD_ISSUE);
  assign rd_req_addr  = rd_req_valid ? addr_q : '0;
  assign wr_addr      = wr_valid ? dw_lo[ADDR_WIDTH+1:2] : '0;
  assign wr_data      = wr_valid ? dw_hi : '0;
  assign wr_be        = wr_valid ? be_q : '0;

  assign {byte_count, low2} = be_to_bytecount_lowaddr(be_q);

  // TD/EP/AT are zero; completion status is always successful.
  assign desc.dw0   = {1'b0, CPLD, 1'b0, tc_q, 4'b0, 1'b0, 1'b0, attr_q, 2'b00, 10'd1};
  assign desc.dw1   = {cfg_bus_number, cfg_device_number, cfg_function_number,
                       3'b000, 1'b0, byte_count};
  assign desc.dw2   = {reqid_q, tag_q, 1'b0, la_hi_q, low2};
  assign desc.rdata = rdata_q;

  pcie_cpld_tx_64 u_cpld_tx (
    .clk       (user_clk),
    .rst_n     (user_reset_n),
    .start     (state_q == ST_CPL),
    .desc      (desc),
    .tx_buf_av (tx_buf_av),
    .tx        (s_axis_tx),
    .done      (cpl_done),
    .state     (tx_state)
  );

  assign dbg.top = state_q;
  assign dbg.tx  = tx_state;

  assign unused_rx = ^{m_axis_rx.tkeep, m_axis_rx.tuser, m_axis_rx.tdata};

endmodule

// File: tb/tb_pcie_tlp_completer_64.sv
module tb_pcie_tlp_completer_64;
  import pcie_tlp_pkg::*;

  logic        clk = 1'b0;
  logic        user_reset_n;
  logic [5:0]  tx_buf_av;
  logic [7:0]  cfg_bus_number;
  logic [4:0]  cfg_device_number;
  logic [2:0]  cfg_function_number;
  logic        rd_req_valid;
  logic [9:0]  rd_req_addr;
  logic        rd_req_ready;
  logic        rd_rsp_valid;
  logic [31:0] rd_rsp_data;
  logic        wr_valid;
  logic [9:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;
  logic        ur_drop;
  dbg_t        dbg;

  pcie_tlp_completer_64_if #(.DATA_W(64), .USER_W(22)) rx_if ();
  pcie_tlp_completer_64_if #(.DATA_W(64), .USER_W(4))  tx_if ();

  pcie_tlp_completer_64 #(.ADDR_WIDTH(10), .C_DATA_WIDTH(64)) dut (
    .user_clk            (clk),
    .user_reset_n        (user_reset_n),
    .m_axis_rx           (rx_if),
    .s_axis_tx           (tx_if),
    .tx_buf_av           (tx_buf_av),
    .cfg_bus_number      (cfg_bus_number),
    .cfg_device_number   (cfg_device_number),
    .cfg_function_number (cfg_function_number),
    .rd_req_valid        (rd_req_valid),
    .rd_req_addr         (rd_req_addr),
    .rd_req_ready        (rd_req_ready),
    .rd_rsp_valid        (rd_rsp_valid),
    .rd_rsp_data         (rd_rsp_data),
    .wr_valid            (wr_valid),
    .wr_addr             (wr_addr),
    .wr_data             (wr_data),
    .wr_be               (wr_be),
    .ur_drop             (ur_drop),
    .dbg                 (dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  int ur_seen = 0;
  logic rd_prev = 1'b0;
  logic [72:0] exp_tx_q[$];  // {tlast, tkeep, tdata}
  logic [45:0] exp_wr_q[$];  // {addr, data, be}
  logic [9:0]  exp_rd_q[$];  // read request address

  function automatic void check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endfunction

  function automatic void unexpected(input string name, input logic [127:0] act);
    checks++;
    failures++;
    $display("FAIL %s actual=%0h expected=none", name, act);
  endfunction

  // Monitor: sample away from the active edge, pop and compare on each output event.
  always @(negedge clk) begin
    if (user_reset_n) begin
      if (tx_if.tvalid && tx_if.tready) begin
        if (exp_tx_q.size() == 0) unexpected("tx_beat", {tx_if.tlast, tx_if.tkeep, tx_if.tdata});
        else check("tx_beat", {tx_if.tlast, tx_if.tkeep, tx_if.tdata}, exp_tx_q.pop_front());
      end
      if (wr_valid) begin
        if (exp_wr_q.size() == 0) unexpected("wr_strobe", {wr_addr, wr_data, wr_be});
        else check("wr_strobe", {wr_addr, wr_data, wr_be}, exp_wr_q.pop_front());
      end
      if (rd_req_valid && !rd_prev) begin
        if (exp_rd_q.size() == 0) unexpected("rd_req", rd_req_addr);
        else check("rd_req_addr", rd_req_addr, exp_rd_q.pop_front());
      end
      if (ur_drop) ur_seen++;
    end
    rd_prev = rd_req_valid;
  end

  // ---------------- driver tasks ----------------
  task automatic send_beat(input logic [63:0] d, input logic last, input logic [21:0] u);
    int n;
    n = 0;
    rx_if.tdata  = d;
    rx_if.tkeep  = 8'hFF;
    rx_if.tlast  = last;
    rx_if.tuser  = u;
    rx_if.tvalid = 1'b1;
    forever begin
      @(negedge clk);
      if (rx_if.tready) break;
      n++;
      if (n > 200) begin
        unexpected("rx_accept_timeout", n);
        break;
      end
    end
    @(posedge clk); #1;
    rx_if.tvalid = 1'b0;
    rx_if.tlast  = 1'b0;
  endtask

  // Handshake the read request then return data rsp_delay cycles later
  // (0 = data in the same cycle as rd_req_ready).
  task automatic service_read(input logic [31:0] rdata, input int rsp_delay);
    int n;
    n = 0;
    while (rd_req_valid !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) begin
      unexpected("rd_req_timeout", n);
      return;
    end
    rd_req_ready = 1'b1;
    if (rsp_delay == 0) begin
      rd_rsp_valid = 1'b1;
      rd_rsp_data  = rdata;
    end
    @(posedge clk); #1;
    rd_req_ready = 1'b0;
    rd_rsp_valid = 1'b0;
    if (rsp_delay > 0) begin
      repeat (rsp_delay - 1) begin @(posedge clk); #1; end
      rd_rsp_valid = 1'b1;
      rd_rsp_data  = rdata;
      @(posedge clk); #1;
      rd_rsp_valid = 1'b0;
    end
  endtask

  task automatic send_mrd(input logic [31:0] dw0, input logic [31:0] dw1, input logic [31:0] addr,
                          input logic [31:0] rdata, input int rsp_delay);
    send_beat({dw1, dw0}, 1'b0, 22'h4);
    send_beat({32'h0, addr}, 1'b1, 22'h4);
    service_read(rdata, rsp_delay);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_tx_q.size() != 0 || exp_wr_q.size() != 0 || exp_rd_q.size() != 0) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) unexpected("drain_timeout", n);
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic check_outputs_idle(input string tag);
    check({tag, "_rx_tready"},   rx_if.tready, 1'b0);
    check({tag, "_tx_tvalid"},   tx_if.tvalid, 1'b0);
    check({tag, "_tx_tdata"},    tx_if.tdata, 64'h0);
    check({tag, "_rd_req"},      {rd_req_valid, rd_req_addr}, 11'h0);
    check({tag, "_wr"},          {wr_valid, wr_addr, wr_data, wr_be}, 47'h0);
    check({tag, "_ur_drop"},     ur_drop, 1'b0);
    check({tag, "_state"},       dbg.top, ST_IDLE);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [63:0] stall_exp;
    int n;
    user_reset_n        = 1'b0;
    rx_if.tdata         = '0;
    rx_if.tkeep         = '0;
    rx_if.tlast         = 1'b0;
    rx_if.tvalid        = 1'b0;
    rx_if.tuser         = '0;
    tx_if.tready        = 1'b1;
    tx_buf_av           = 6'd8;
    cfg_bus_number      = 8'h01;
    cfg_device_number   = 5'h00;
    cfg_function_number = 3'h0;
    rd_req_ready        = 1'b0;
    rd_rsp_valid        = 1'b0;
    rd_rsp_data         = '0;

    #3;
    check_outputs_idle("reset");
    check("reset_tx_tuser", tx_if.tuser, 4'h0);
    repeat (3) @(posedge clk);
    #1 user_reset_n = 1'b1;
    @(posedge clk); #1;

    // 1: basic MRd, 3-cycle read latency
    exp_rd_q.push_back(10'h004);
    exp_tx_q.push_back({1'b0, 8'hFF, 64'h01000004_4A000001});
    exp_tx_q.push_back({1'b1, 8'hFF, 64'hDEADBEEF_12340A10});
    send_mrd(32'h00000001, 32'h12340A0F, 32'h00000010, 32'hDEADBEEF, 3);
    wait_drain();

    // 2: MWr, single strobe, no completion
    exp_wr_q.push_back({10'h002, 32'hCAFEF00D, 4'h3});
    send_beat({32'h56780103, 32'h40000001}, 1'b0, 22'h4);
    send_beat({32'hCAFEF00D, 32'h00000008}, 1'b1, 22'h4);
    wait_drain();

    // 3: MRd firstBE=0100, TC=3/attr=2, other completer ID, data with ready
    cfg_bus_number      = 8'h5A;
    cfg_device_number   = 5'h03;
    cfg_function_number = 3'h5;
    exp_rd_q.push_back(10'h009);
    exp_tx_q.push_back({1'b0, 8'hFF, 64'h5A1D0001_4A302001});
    exp_tx_q.push_back({1'b1, 8'hFF, 64'h13579BDF_ABCD1126});
    send_mrd(32'h00302001, 32'hABCD1104, 32'h00000024, 32'h13579BDF, 0);
    wait_drain();
    cfg_bus_number      = 8'h01;
    cfg_device_number   = 5'h00;
    cfg_function_number = 3'h0;

    // 4: no TX credits, then TX backpressure; firstBE=0110
    stall_exp = 64'h01000002_4A000001;
    tx_if.tready = 1'b0;
    tx_buf_av    = 6'd0;
    exp_rd_q.push_back(10'h00F);
    exp_tx_q.push_back({1'b0, 8'hFF, stall_exp});
    exp_tx_q.push_back({1'b1, 8'hFF, 64'h0BADF00D_0022013D});
    send_mrd(32'h00000001, 32'h00220106, 32'h0000003C, 32'h0BADF00D, 1);
    repeat (4) begin
      @(negedge clk);
      check("no_credit_tvalid", tx_if.tvalid, 1'b0);
    end
    @(posedge clk); #1;
    tx_buf_av = 6'd6;
    n = 0;
    while (!tx_if.tvalid && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) unexpected("tx_valid_timeout", n);
    repeat (5) begin
      @(negedge clk);
      check("stall_tvalid", tx_if.tvalid, 1'b1);
      check("stall_tdata", {tx_if.tlast, tx_if.tdata}, {1'b0, stall_exp});
      check("stall_rx_tready", rx_if.tready, 1'b0);
    end
    @(posedge clk); #1;
    tx_if.tready = 1'b1;
    wait_drain();

    // 5: three discards: len=2, no BAR0 hit, poisoned
    send_beat({32'h12340A0F, 32'h00000002}, 1'b0, 22'h4);
    send_beat({32'h0, 32'h00000010}, 1'b0, 22'h4);
    send_beat({32'h11111111, 32'h0}, 1'b1, 22'h4);
    send_beat({32'h12340A0F, 32'h00000001}, 1'b0, 22'h0);
    send_beat({32'h0, 32'h00000010}, 1'b1, 22'h0);
    send_beat({32'h12340A0F, 32'h00000001}, 1'b0, 22'h6);
    send_beat({32'h0, 32'h00000010}, 1'b1, 22'h6);
    wait_drain();
    check("ur_drop_count", ur_seen, 3);

    // 6: reset while waiting for read data, then a clean MRd
    exp_rd_q.push_back(10'h010);
    send_beat({32'h0000070F, 32'h00000001}, 1'b0, 22'h4);
    send_beat({32'h0, 32'h00000040}, 1'b1, 22'h4);
    rd_req_ready = 1'b1;
    @(posedge clk); #1;
    rd_req_ready = 1'b0;
    @(posedge clk); #1;
    check("pre_reset_state", dbg.top, ST_RD_WAIT);
    user_reset_n = 1'b0;
    #1;
    check_outputs_idle("midreset");
    repeat (2) @(posedge clk);
    #1 user_reset_n = 1'b1;
    rd_rsp_valid = 1'b1;
    rd_rsp_data  = 32'hFFFFFFFF;
    @(posedge clk); #1;
    rd_rsp_valid = 1'b0;
    check("stale_rsp_state", dbg.top, ST_IDLE);
    check("stale_rsp_tvalid", tx_if.tvalid, 1'b0);
    exp_rd_q.push_back(10'h004);
    exp_tx_q.push_back({1'b0, 8'hFF, 64'h01000004_4A000001});
    exp_tx_q.push_back({1'b1, 8'hFF, 64'h01234567_12340A10});
    send_mrd(32'h00000001, 32'h12340A0F, 32'h00000010, 32'h01234567, 2);
    wait_drain();

    // final report
    check("exp_tx_left", exp_tx_q.size(), 0);
    check("exp_wr_left", exp_wr_q.size(), 0);
    check("exp_rd_left", exp_rd_q.size(), 0);
    check("ur_drop_final", ur_seen, 3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0t expected=finish", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pcie_tlp_completer_64.md
Name: pcie_tlp_completer_64

Overview:
- Target-side TLP responder on the 7-series PCIe endpoint user interface, 64-bit AXI-stream.
- Consumes requests from the core's m_axis_rx stream: single-DW memory reads and writes, 3DW header, BAR0 hits only.
- Drives a simple register read/write port and returns CplD TLPs on the core's s_axis_tx stream.
- Sits between the endpoint wrapper and the portal/register fabric, in the user_clk domain.

Parameters:
- ADDR_WIDTH, 10, DW-address width of the register port. Taken from TLP address bits [ADDR_WIDTH+1:2].
- C_DATA_WIDTH, 64, AXI data width. Only 64 is legal; elaboration error otherwise.

Ports:
- user_clk  in  1  user clock from the PCIe core
- user_reset_n  in  1  asynchronous active-low reset
- m_axis_rx_tdata/tkeep/tlast/tvalid  in  64/8/1/1  RX TLP stream
- m_axis_rx_tready  out  1  RX accept
- m_axis_rx_tuser  in  22  [1]=err_fwd, [2]=BAR0 hit
- s_axis_tx_tdata/tkeep/tlast/tvalid  out  64/8/1/1  TX completion stream
- s_axis_tx_tuser  out  4  constant 0
- s_axis_tx_tready  in  1  TX accept
- tx_buf_av  in  6  core TX buffers free
- cfg_bus_number/cfg_device_number/cfg_function_number  in  8/5/3  completer ID
- rd_req_valid  out  1  register read request
- rd_req_addr  out  ADDR_WIDTH  read DW address
- rd_req_ready  in  1  read request accepted
- rd_rsp_valid  in  1  read data valid, arbitrary latency
- rd_rsp_data  in  32  read data
- wr_valid  out  1  one-cycle write strobe, no backpressure
- wr_addr  out  ADDR_WIDTH  write DW address
- wr_data  out  32  write data
- wr_be  out  4  first-DW byte enables
- ur_drop  out  1  one-cycle pulse per discarded TLP

Behaviour:
- Reset: all outputs 0, FSM in IDLE. Reset asserted mid-TLP abandons the TLP; no partial TX beat follows reset.
- Header decode (beat0, DW0=[31:0], DW1=[63:32]):
  - fmt=DW0[30:29], type=DW0[28:24], TC=DW0[22:20], attr=DW0[13:12], len=DW0[9:0].
  - reqid=DW1[31:16], tag=DW1[15:8], firstBE=DW1[3:0].
- Beat1 of a 3DW TLP: DW2 (address) at [31:0]; for MWr, DW3 (data) at [63:32].
- Accepted TLPs:
  - MRd: fmt=00, type=00000, len=1.
  - MWr: fmt=10, type=00000, len=1.
  - Both require tuser[2]=1 and tuser[1]=0 on beat0. Anything else goes to DISCARD.
- FSM states:
  - IDLE (tready=1): beat0 accepted and decodes OK -> HDR2; otherwise -> DISCARD, or back to IDLE if tlast=1. ur_drop pulses once per discarded TLP on the beat0 accept.
  - HDR2 (tready=1): on beat1 accept, latch address.
    - MWr: pulse wr_valid with DW3 and firstBE the same cycle beat1 is accepted -> IDLE.
    - MRd: -> RD_ISSUE.
    - If beat1 has tlast=0 (malformed): -> DISCARD.
  - RD_ISSUE (tready=0): rd_req_valid=1 until rd_req_ready -> RD_WAIT. If rd_rsp_valid arrives in the same cycle as ready, go directly to TX0.
  - RD_WAIT (tready=0): rd_rsp_valid latches data -> TX0.
  - TX0: beat0 is presented only once tx_buf_av != 0. tvalid is held with stable data until tready.
    - tdata = {DW1c, DW0c}, tkeep=FF, tlast=0.
    - DW0c: fmt=10, type=01010, TC, attr, len=1.
    - DW1c: {bus, dev, func, status=000, BCM=0, byte_count}.
  - TX1: tdata = {rdata, DW2c}, tkeep=FF, tlast=1; on tready -> IDLE.
    - DW2c: {reqid, tag, 0, lower_addr[6:0]}.
  - DISCARD (tready=1): sink beats until tlast accepted -> IDLE.
- Byte count and lower address from firstBE:
  - firstBE=0000: byte_count=1, low2=00.
  - Otherwise: byte_count = highest set index - lowest set index + 1; low2 = lowest set index.
  - lower_addr = {addr[6:2], low2}.
- Concurrency: one read outstanding. RX is back-pressured from RD_ISSUE through TX1, so no queueing is required.

Decomposition:
- Package pcie_tlp_pkg:
  - fmt/type constants: MRD32, MWR32, CPLD.
  - header field offsets.
  - function be_to_bytecount_lowaddr(firstBE) -> {byte_count[11:0], low2[1:0]}.
- One sub-module, pcie_cpld_tx_64: TX0/TX1 beat sequencing and hold-until-tready, fed by a latched completion descriptor.

Test Plan:
- MRd: DW0=0x00000001, DW1=0x12340A0F, addr 0x00000010, BAR0; rd_rsp_data=0xDEADBEEF after 3 cycles; bus/dev/func=01/00/0.
  -> rd_req_addr=4.
  -> TX beat0 = {0x01000004, 0x4A000001}.
  -> TX beat1 = {0xDEADBEEF, 0x12340A10}, tlast=1.
- MWr: DW0=0x40000001, firstBE=0x3, addr 0x8, data 0xCAFEF00D.
  -> wr_valid single cycle, wr_addr=2, wr_be=3, wr_data=0xCAFEF00D; no TX.
- MRd with firstBE=0100 -> completion byte_count=1, lower_addr[1:0]=10.
- s_axis_tx_tready held 0 for 5 cycles in TX0 -> tdata/tvalid stable; m_axis_rx_tready=0 throughout.
- MRd len=2, then MRd with tuser[2]=0, then MRd with tuser[1]=1 -> three ur_drop pulses; all beats sunk; no rd_req_valid.
- user_reset_n deasserted in RD_WAIT -> all outputs 0 immediately. After release, a new MRd completes normally and the stale rd_rsp_valid is ignored.
